load_use_stall_ctrl: RTL and testbench

//  Generalised load-use hazard controller for the 5-stage MIPS pipeline.
//  - Detects when an ID-stage instruction reads a register that a load in EX has not yet written.
//  - Asserts PC / IF-ID hold and an ID-EX bubble for LOAD_LAT cycles.
//  - Suppresses or cancels stalls on a taken branch/jump in MEM.
//  - Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/src_match.sv | 15 +
 rtl/load_use_stall_ctrl.sv | 112 +++++++++++
 tb/tb_load_use_stall_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard controller.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam logic [REG_AW_DEF-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/src_match.sv
// One ID source-register comparator against the EX load destination, gated by its use flag.
module src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic [REG_AW-1:0] dst,
  output logic              match
);

  assign match = use_src & (src == dst);

endmodule

// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard controller: holds PC and IF/ID and bubbles ID/EX for LOAD_LAT cycles,
// cancelled by a taken redirect in MEM; counts stalled cycles with saturation.
module load_use_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              rs_use_id,
  input  logic              rt_use_id,
  input  logic              redirect_mem,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic [1:0]        bubble_left,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  stall_state_e      state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic rs_match, rt_match, dst_exempt, hit, stall;
  logic [1:0] left;

  src_match #(.REG_AW(REG_AW)) u_rs_match (
    .src     (rs_id),
    .use_src (rs_use_id),
    .dst     (rd_ex),
    .match   (rs_match)
  );

  src_match #(.REG_AW(REG_AW)) u_rt_match (
    .src     (rt_id),
    .use_src (rt_use_id),
    .dst     (rd_ex),
    .match   (rt_match)
  );

  // rs and rt matching together is still one hazard, hence the OR.
  assign dst_exempt = (ZERO_EXEMPT != 0) && (rd_ex == REG_AW'(ZERO_REG));
  assign hit        = load_ex & ~dst_exempt & (rs_match | rt_match);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    left    = 2'd0;
    unique case (state_q)
      IDLE: begin
        stall = hit & ~redirect_mem;
        if (stall) begin
          left = LAT_M1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = LAT_M1;
          end
        end
      end
      STALL: begin
        stall = ~redirect_mem;
        left  = cnt_q - 2'd1;
        cnt_d = cnt_q - 2'd1;
        if (redirect_mem || cnt_d == 2'd0) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    perf_d = perf_q;
    if (stall && perf_q != {PERF_W{1'b1}}) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  // Gated by rst_n so a live hit cannot hold the pipeline while reset is asserted.
  assign stall_pc     = stall & rst_n;
  assign stall_ifid   = stall & rst_n;
  assign bubble_idex  = stall & rst_n;
  assign bubble_left  = left & {2{rst_n}};
  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Bench for load_use_stall_ctrl: four parameterisations share one stimulus stream.
module tb_load_use_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_ex = 1'b0;
  logic [4:0] rd_ex = '0, rs_id = '0, rt_id = '0;
  logic rs_use_id = 1'b0, rt_use_id = 1'b0, redirect_mem = 1'b0;

  logic [3:0] sp, si, bi;
  logic [3:0][1:0] bl;
  logic [3:0][15:0] sc;

  int checks = 0;
  int errors = 0;

  int lat_i [4] = '{1, 2, 3, 1};
  int ze_i  [4] = '{1, 1, 1, 0};

  // Reference: pending stall cycles still owed after the current one, plus the counter.
  int m_pend [4];
  int m_next [4];
  int m_ctr  [4];
  int m_bl   [4];
  bit m_stall[4];

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(1), .PERF_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .load_ex(load_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .rs_use_id(rs_use_id), .rt_use_id(rt_use_id), .redirect_mem(redirect_mem),
    .stall_pc(sp[0]), .stall_ifid(si[0]), .bubble_idex(bi[0]), .bubble_left(bl[0]), .stall_cycles(sc[0]));
  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(2), .ZERO_EXEMPT(1), .PERF_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .load_ex(load_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .rs_use_id(rs_use_id), .rt_use_id(rt_use_id), .redirect_mem(redirect_mem),
    .stall_pc(sp[1]), .stall_ifid(si[1]), .bubble_idex(bi[1]), .bubble_left(bl[1]), .stall_cycles(sc[1]));
  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .ZERO_EXEMPT(1), .PERF_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .load_ex(load_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .rs_use_id(rs_use_id), .rt_use_id(rt_use_id), .redirect_mem(redirect_mem),
    .stall_pc(sp[2]), .stall_ifid(si[2]), .bubble_idex(bi[2]), .bubble_left(bl[2]), .stall_cycles(sc[2]));
  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(0), .PERF_W(16)) u_d3 (
    .clk(clk), .rst_n(rst_n), .load_ex(load_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .rs_use_id(rs_use_id), .rt_use_id(rt_use_id), .redirect_mem(redirect_mem),
    .stall_pc(sp[3]), .stall_ifid(si[3]), .bubble_idex(bi[3]), .bubble_left(bl[3]), .stall_cycles(sc[3]));

  function automatic logic [20:0] obs(int i);
    return {sp[i], si[i], bi[i], bl[i], sc[i]};
  endfunction

  function automatic logic [20:0] exp_vec(int i);
    logic [1:0]  b = 2'(m_bl[i]);
    logic [15:0] c = 16'(m_ctr[i]);
    return {m_stall[i], m_stall[i], m_stall[i], b, c};
  endfunction

  function automatic void model_eval();
    for (int i = 0; i < 4; i++) begin
      bit hit;
      if (!rst_n) begin
        m_pend[i] = 0; m_next[i] = 0; m_ctr[i] = 0; m_bl[i] = 0; m_stall[i] = 0;
        continue;
      end
      hit = load_ex && !(ze_i[i] != 0 && rd_ex == 0) &&
            ((rs_use_id && rs_id == rd_ex) || (rt_use_id && rt_id == rd_ex));
      if (m_pend[i] > 0) begin
        m_stall[i] = !redirect_mem;
        m_bl[i]    = m_pend[i] - 1;
        m_next[i]  = redirect_mem ? 0 : m_pend[i] - 1;
      end else begin
        m_stall[i] = hit && !redirect_mem;
        m_bl[i]    = m_stall[i] ? lat_i[i] - 1 : 0;
        m_next[i]  = m_stall[i] ? lat_i[i] - 1 : 0;
      end
    end
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rst_n) begin
        m_pend[i] = m_next[i];
        if (m_stall[i] && m_ctr[i] < 65535) m_ctr[i]++;
      end
    end
    #1;
  endtask

  task automatic drive(bit ld, int rd, int rs, int rt, bit rsu, bit rtu, bit redir);
    load_ex = ld; rd_ex = 5'(rd); rs_id = 5'(rs); rt_id = 5'(rt);
    rs_use_id = rsu; rt_use_id = rtu; redirect_mem = redir;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1, 8, 8, 0, 1, 0, 0);
    settle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 21'd0) begin
        errors++;
        $display("FAIL reset inst%0d got %h want %h", i, obs(i), 21'd0);
      end
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_basic_hit();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1, 8, 8, 3, 1, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      settle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL basic_hit c%0d inst%0d got %h want %h", c, i, obs(i), exp_vec(i));
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sc[i] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL basic_count inst%0d got %0d want %0d", i, sc[i], i + 1);
      end
    end
  endtask

  task automatic test_zero_reg();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 0, 4, 0, 0, 1, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      settle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL zero_reg c%0d inst%0d got %h want %h", c, i, obs(i), exp_vec(i));
        end
      end
      if (c == 0) begin
        checks++;
        if (sp !== 4'b1000) begin
          errors++;
          $display("FAIL zero_reg_pc got %b want %b", sp, 4'b1000);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_same();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 9, 9, 9, 1, 1, 1);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      settle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL redirect_same c%0d inst%0d got %h want %h", c, i, obs(i), exp_vec(i));
        end
      end
      checks++;
      if (sp !== 4'b0000) begin
        errors++;
        $display("FAIL redirect_same_pc c%0d got %b want 0000", c, sp);
      end
      tick();
    end
  endtask

  task automatic test_redirect_mid();
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      drive(1, 7, 2, 7, 0, 1, 0);
      else if (c == 1) drive(0, 0, 0, 0, 0, 0, 1);
      else             drive(0, 0, 0, 0, 0, 0, 0);
      settle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL redirect_mid c%0d inst%0d got %h want %h", c, i, obs(i), exp_vec(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_double_src();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1, 5, 5, 5, 1, 1, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      settle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL double_src c%0d inst%0d got %h want %h", c, i, obs(i), exp_vec(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_no_use();
    drive(1, 12, 12, 3, 0, 1, 0);
    settle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_vec(i) || sp[i] !== 1'b0) begin
        errors++;
        $display("FAIL no_use inst%0d got %h want %h", i, obs(i), exp_vec(i));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 6, 6, 0, 1, 0, 0);
    settle();
    tick();
    rst_n = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 21'd0) begin
        errors++;
        $display("FAIL reset_mid inst%0d got %h want %h", i, obs(i), 21'd0);
      end
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL reset_release inst%0d got %h want %h", i, obs(i), exp_vec(i));
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0);
      settle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random c%0d inst%0d got %h want %h", c, i, obs(i), exp_vec(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 8, 8, 0, 1, 0, 0);
    for (int c = 0; c < 70000; c++) begin
      settle();
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sc[i] !== 16'hFFFF || obs(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL saturation inst%0d got %h want %h", i, obs(i), exp_vec(i));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_next[i] = 0; m_ctr[i] = 0; m_bl[i] = 0; m_stall[i] = 0;
    end
    #2;
    test_reset();
    test_basic_hit();
    test_zero_reg();
    test_redirect_same();
    test_redirect_mid();
    test_double_src();
    test_no_use();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
